ntt_coef_loader: RTL



---
 rtl/ntt_pkg.sv | 20 ++
 rtl/ntt_lane_packer.sv | 42 ++++
 rtl/ntt_coef_loader.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// Shared constants and types for the NTT coefficient path.
// Widths, BRAM geometry and the loader state encoding.
package ntt_pkg;
   localparam int CW    = 32;
   localparam int DW    = 128;
   localparam int WL    = 512;
   localparam int LANES = DW / CW;
   localparam int LNW   = $clog2(LANES);
   localparam int LW    = $clog2(WL);
   localparam int AW    = 13;

   localparam logic [LANES-1:0] WE_ALL = 4'hF;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      FLUSH,
      DONE
   } ld_state_e;
endpackage

// File: rtl/ntt_lane_packer.sv
// Four-lane coefficient packer: inserts one word per accept,
// exposes the line including the incoming word, zero-clears.
module ntt_lane_packer
   import ntt_pkg::*;
(
   input  logic          CLK,
   input  logic          RSTN,
   input  logic          clr,
   input  logic          ins,
   input  logic [CW-1:0] din,
   output logic [DW-1:0] line,
   output logic          full
);

   logic [DW-1:0]  pend_q;
   logic [LNW-1:0] lane_q;

   // held lanes with the incoming word dropped into the current lane
   always_comb begin
      line = pend_q;
      for (int i = 0; i < LANES; i++) begin
         if (lane_q == LNW'(i)) line[i*CW +: CW] = din;
      end
   end

   assign full = (lane_q == LNW'(LANES - 1));

   // insert a word, or clear once the line is handed off
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         pend_q <= '0;
         lane_q <= '0;
      end else if (clr || (ins && full)) begin
         pend_q <= '0;
         lane_q <= '0;
      end else if (ins) begin
         pend_q <= line;
         lane_q <= lane_q + LNW'(1);
      end
   end

endmodule

// File: rtl/ntt_coef_loader.sv
// AXI-Stream to coefficient-BRAM loader: packs four words per
// line and writes each line at (base + idx) mod WL, shifted by 2.
module ntt_coef_loader
   import ntt_pkg::*;
#(
   parameter int N_COEF = 256
) (
   input  logic          CLK,
   input  logic          RSTN,
   input  logic          start,
   input  logic [LW-1:0] base_line,
   input  logic [CW-1:0] s_tdata,
   input  logic          s_tvalid,
   output logic          s_tready,
   input  logic          s_tlast,
   output logic          bram_en,
   output logic [3:0]    bram_we,
   output logic [AW-1:0] bram_a,
   output logic [DW-1:0] bram_di,
   output logic          busy,
   output logic          done,
   output logic          err_tlast
);

   localparam int CNW = $clog2(N_COEF);
   localparam logic [CNW-1:0] LAST = CNW'(N_COEF - 1);

   ld_state_e      state_q;
   ld_state_e      state_d;
   logic [LW-1:0]  base_q;
   logic [LW-1:0]  line_q;
   logic [CNW-1:0] cnt_q;
   logic [LW-1:0]  addr;
   logic [DW-1:0]  line_w;
   logic           full;
   logic           go;
   logic           acc;
   logic           last;
   logic           term;
   logic           wr;

   assign go   = start && (state_q == IDLE);
   assign acc  = s_tvalid && (state_q == LOAD);
   assign last = (cnt_q == LAST);
   assign term = acc && (last || s_tlast);
   assign wr   = acc && (full || last || s_tlast);
   assign addr = base_q + line_q;

   assign s_tready = (state_q == LOAD);
   assign busy     = (state_q == LOAD) || (state_q == FLUSH);
   assign done     = (state_q == DONE);

   ntt_lane_packer u_pack (
      .CLK  (CLK),
      .RSTN (RSTN),
      .clr  (go || term),
      .ins  (acc),
      .din  (s_tdata),
      .line (line_w),
      .full (full)
   );

   // state register
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // next-state: launch, run to terminating word, flush, pulse done
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = LOAD;
         LOAD:    if (term) state_d = FLUSH;
         FLUSH:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // launch capture, coefficient and line counters
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         base_q <= '0;
         line_q <= '0;
         cnt_q  <= '0;
      end else if (go) begin
         base_q <= base_line;
         line_q <= '0;
         cnt_q  <= '0;
      end else if (acc) begin
         cnt_q <= cnt_q + CNW'(1);
         if (wr) line_q <= line_q + LW'(1);
      end
   end

   // sticky tlast mismatch, cleared by a new launch
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN)                     err_tlast <= 1'b0;
      else if (go)                   err_tlast <= 1'b0;
      else if (acc && (last != s_tlast)) err_tlast <= 1'b1;
   end

   // registered BRAM write port, one strobe per formed line
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         bram_en <= 1'b0;
         bram_we <= '0;
         bram_a  <= '0;
         bram_di <= '0;
      end else begin
         bram_en <= wr;
         bram_we <= wr ? WE_ALL : '0;
         if (wr) begin
            bram_a  <= AW'({addr, 2'b00});
            bram_di <= line_w;
         end
      end
   end

endmodule
